// File: rtl/mem_bridge_pkg.sv
// rtl/mem_bridge_pkg.sv - shared types and constants for the CPU-to-physical-memory bridge
package mem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } mem_bridge_state_t;

    localparam logic [3:0] MEM_BE_FULL = 4'hF;

endpackage

// File: rtl/mem_watchdog.sv
// rtl/mem_watchdog.sv - transaction timeout counter; used only when MEM_TIMEOUT_EN is defined
module mem_watchdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    // expired flags the final counted cycle so the abort lands exactly TIMEOUT_CYCLES in
    assign expired = count_en && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_bridge.sv
// rtl/mem_bridge.sv - CPU word request to req/gnt/rvalid memory port bridge; optional timeout via MEM_TIMEOUT_EN
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [3:0]  cpu_byte_enable,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_resp,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    output logic        pmem_req,
    output logic        pmem_we,
    output logic [3:0]  pmem_be,
    output logic [31:0] pmem_addr,
    output logic [31:0] pmem_wdata,
    input  logic        pmem_gnt,
    input  logic        pmem_rvalid,
    input  logic [31:0] pmem_rdata
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $fatal(1, "mem_bridge: TIMEOUT_CYCLES must be at least 1");
    end

    mem_bridge_state_t state, state_d;
    logic        resp_d, err_d, req_d, we_d;
    logic [3:0]  be_d;
    logic [31:0] addr_d, wdata_d, rdata_d;
    logic        expired;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = &{1'b0, cpu_address[1:0]};

`ifdef MEM_TIMEOUT_EN
    mem_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear    ((state == IDLE) && (state_d == REQ)),
        .count_en ((state == REQ) || (state == WAIT)),
        .expired  (expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d = state;
        resp_d  = 1'b0;
        err_d   = 1'b0;
        req_d   = pmem_req;
        we_d    = pmem_we;
        be_d    = pmem_be;
        addr_d  = pmem_addr;
        wdata_d = pmem_wdata;
        rdata_d = cpu_rdata;
        case (state)
            IDLE: begin
                if (cpu_read || cpu_write) begin
                    addr_d  = {cpu_address[31:2], 2'b00};
                    we_d    = cpu_write;
                    be_d    = cpu_write ? cpu_byte_enable : MEM_BE_FULL;
                    wdata_d = cpu_wdata;
                    if (cpu_write && (cpu_byte_enable == 4'h0)) begin
                        state_d = RESP;
                        resp_d  = 1'b1;
                    end else begin
                        state_d = REQ;
                        req_d   = 1'b1;
                    end
                end
            end
            REQ: begin
                // a same-cycle completion beats expiry; a bare grant does not
                if (pmem_gnt && pmem_rvalid) begin
                    req_d   = 1'b0;
                    state_d = RESP;
                    resp_d  = 1'b1;
                    if (!pmem_we) rdata_d = pmem_rdata;
                end else if (expired) begin
                    req_d   = 1'b0;
                    state_d = RESP;
                    resp_d  = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else if (pmem_gnt) begin
                    req_d   = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (pmem_rvalid) begin
                    state_d = RESP;
                    resp_d  = 1'b1;
                    if (!pmem_we) rdata_d = pmem_rdata;
                end else if (expired) begin
                    state_d = RESP;
                    resp_d  = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cpu_resp   <= 1'b0;
            cpu_err    <= 1'b0;
            cpu_rdata  <= '0;
            pmem_req   <= 1'b0;
            pmem_we    <= 1'b0;
            pmem_be    <= '0;
            pmem_addr  <= '0;
            pmem_wdata <= '0;
        end else begin
            state      <= state_d;
            cpu_resp   <= resp_d;
            cpu_err    <= err_d;
            cpu_rdata  <= rdata_d;
            pmem_req   <= req_d;
            pmem_we    <= we_d;
            pmem_be    <= be_d;
            pmem_addr  <= addr_d;
            pmem_wdata <= wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_bridge.sv
// tb/tb_mem_bridge.sv - randomized self-checking bench for mem_bridge against a word-memory reference model
module tb_mem_bridge;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_read, cpu_write;
    logic [3:0]  cpu_byte_enable;
    logic [31:0] cpu_address, cpu_wdata;
    logic        cpu_resp, cpu_err;
    logic [31:0] cpu_rdata;
    logic        pmem_req, pmem_we;
    logic [3:0]  pmem_be;
    logic [31:0] pmem_addr, pmem_wdata;
    logic        pmem_gnt, pmem_rvalid;
    logic [31:0] pmem_rdata;

    always #5 clk = ~clk;

    mem_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .cpu_read        (cpu_read),
        .cpu_write       (cpu_write),
        .cpu_byte_enable (cpu_byte_enable),
        .cpu_address     (cpu_address),
        .cpu_wdata       (cpu_wdata),
        .cpu_resp        (cpu_resp),
        .cpu_rdata       (cpu_rdata),
        .cpu_err         (cpu_err),
        .pmem_req        (pmem_req),
        .pmem_we         (pmem_we),
        .pmem_be         (pmem_be),
        .pmem_addr       (pmem_addr),
        .pmem_wdata      (pmem_wdata),
        .pmem_gnt        (pmem_gnt),
        .pmem_rvalid     (pmem_rvalid),
        .pmem_rdata      (pmem_rdata)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] mem [logic [29:0]];
    logic [31:0] exp_rdata = 32'h0;
    int req_rises = 0;
    bit req_prev  = 1'b0;

    always @(negedge clk) begin
        if (pmem_req && !req_prev) req_rises++;
        req_prev = pmem_req;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [29:0] w);
        logic [31:0] seed;
        seed = {w[15:0], ~w[15:0]};
        return mem.exists(w) ? mem[w] : seed;
    endfunction

    task automatic mem_wr(input logic [29:0] w, input logic [3:0] be, input logic [31:0] d);
        logic [31:0] cur;
        cur = mem_rd(w);
        for (int i = 0; i < 4; i++)
            if (be[i]) cur[8*i +: 8] = d[8*i +: 8];
        mem[w] = cur;
    endtask

    // one CPU request with a memory that grants after gd REQ cycles and completes rv cycles after grant
    task automatic run_txn(input string name, input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wd, input int gd, input int rv,
                           input bit hold);
        logic [29:0] w;
        logic [31:0] exp_a;
        logic [3:0]  exp_be;
        bit noop, exp_err;
        int exp_lat, phase, cnt, lat, seen, viol, rises0;
        w       = addr[31:2];
        exp_a   = {addr[31:2], 2'b00};
        exp_be  = wr ? be : 4'hF;
        noop    = wr && (be == 4'h0);
        exp_err = 1'b0;
        exp_lat = noop ? 1 : 2 + gd + rv;
`ifdef MEM_TIMEOUT_EN
        if (!noop && (1 + gd + rv > TO)) begin
            exp_lat = TO + 1;
            exp_err = 1'b1;
        end
`endif
        phase = 0; cnt = 0; lat = -1; seen = 0; viol = 0;
        rises0 = req_rises;
        @(posedge clk); #1;
        cpu_read = rd; cpu_write = wr; cpu_byte_enable = be; cpu_address = addr; cpu_wdata = wd;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (cpu_resp) begin
                lat = c;
                break;
            end
            if (pmem_req) begin
                seen++;
                if (seen == 1) begin
                    check({name, "_addr"}, pmem_addr, exp_a);
                    check({name, "_be"}, {28'h0, pmem_be}, {28'h0, exp_be});
                    check({name, "_we"}, {31'h0, pmem_we}, {31'h0, wr});
                    if (wr) check({name, "_wdata"}, pmem_wdata, wd);
                end
                if (pmem_addr !== exp_a || pmem_be !== exp_be || pmem_we !== wr ||
                    (wr && pmem_wdata !== wd)) viol++;
            end
            pmem_gnt = 1'b0; pmem_rvalid = 1'b0; pmem_rdata = $urandom;
            if (phase == 0 && pmem_req) begin
                if (cnt == gd) begin
                    pmem_gnt = 1'b1;
                    if (rv == 0) begin
                        pmem_rvalid = 1'b1; pmem_rdata = mem_rd(w); phase = 2;
                    end else begin
                        phase = 1; cnt = 0;
                    end
                end else begin
                    cnt++;
                    pmem_rvalid = 1'($urandom_range(0, 1));
                end
            end else if (phase == 1) begin
                cnt++;
                pmem_gnt = 1'($urandom_range(0, 1));
                if (cnt == rv) begin
                    pmem_rvalid = 1'b1; pmem_rdata = mem_rd(w); phase = 2;
                end
            end else begin
                pmem_gnt = 1'($urandom_range(0, 1));
                pmem_rvalid = 1'($urandom_range(0, 1));
            end
        end
        if (exp_err) exp_rdata = 32'h0;
        else if (!noop && wr) mem_wr(w, be, wd);
        else if (!noop) exp_rdata = mem_rd(w);
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_rdata"}, cpu_rdata, exp_rdata);
        check({name, "_err"}, {31'h0, cpu_err}, {31'h0, exp_err});
        check({name, "_stable"}, 32'(viol), 32'h0);
        pmem_gnt = 1'($urandom_range(0, 1)); pmem_rvalid = 1'($urandom_range(0, 1));
        if (!hold) begin
            cpu_read = 1'b0; cpu_write = 1'b0;
        end
        @(negedge clk);
        check({name, "_pulse"}, {31'h0, cpu_resp}, 32'h0);
        check({name, "_reqs"}, 32'(req_rises - rises0), noop ? 32'h0 : 32'h1);
        cpu_read = 1'b0; cpu_write = 1'b0;
        pmem_gnt = 1'b0; pmem_rvalid = 1'b0;
    endtask

    task automatic reset_in_wait();
        @(posedge clk); #1;
        cpu_read = 1'b1; cpu_write = 1'b0; cpu_address = 32'h0000_0400; cpu_byte_enable = 4'h0;
        @(negedge clk);
        @(negedge clk);
        check("rst_pre_req", {31'h0, pmem_req}, 32'h1);
        pmem_gnt = 1'b1;
        @(negedge clk);
        pmem_gnt = 1'b0;
        rst = 1'b1;
        #1;
        exp_rdata = 32'h0;
        check("rst_resp", {31'h0, cpu_resp}, 32'h0);
        check("rst_req", {31'h0, pmem_req}, 32'h0);
        check("rst_we", {31'h0, pmem_we}, 32'h0);
        check("rst_be", {28'h0, pmem_be}, 32'h0);
        check("rst_addr", pmem_addr, 32'h0);
        check("rst_wdata", pmem_wdata, 32'h0);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_err", {31'h0, cpu_err}, 32'h0);
        cpu_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pmem_rvalid = 1'b1; pmem_gnt = 1'($urandom_range(0, 1)); pmem_rdata = $urandom;
            @(negedge clk);
            check("rst_late_resp", {31'h0, cpu_resp}, 32'h0);
            check("rst_late_req", {31'h0, pmem_req}, 32'h0);
        end
        pmem_rvalid = 1'b0; pmem_gnt = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        bit r, wbit;
        rst = 1'b1;
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_byte_enable = 4'h0;
        cpu_address = 32'h0; cpu_wdata = 32'h0;
        pmem_gnt = 1'b0; pmem_rvalid = 1'b0; pmem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_resp", {31'h0, cpu_resp}, 32'h0);
        check("reset_req", {31'h0, pmem_req}, 32'h0);
        check("reset_addr", pmem_addr, 32'h0);
        check("reset_rdata", cpu_rdata, 32'h0);
        check("reset_err", {31'h0, cpu_err}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        mem[30'h0000_0401] = 32'hCAFE_F00D;
        run_txn("t1_read", 1'b1, 1'b0, 32'h0000_1007, 4'h0, 32'h0, 0, 0, 1'b0);
        check("t1_cafe", cpu_rdata, 32'hCAFE_F00D);
        run_txn("t2_write", 1'b0, 1'b1, 32'h0000_0020, 4'b0110, 32'h00AB_CD00, 3, 2, 1'b0);
        check("t2_keep", cpu_rdata, 32'hCAFE_F00D);
        run_txn("t3_nobe", 1'b0, 1'b1, 32'h0000_0040, 4'h0, 32'h1234_5678, 0, 0, 1'b0);
        run_txn("t6_hold_a", 1'b1, 1'b0, 32'h0000_0020, 4'h0, 32'h0, 1, 0, 1'b1);
        run_txn("t6_hold_b", 1'b1, 1'b0, 32'h0000_0024, 4'h0, 32'h0, 0, 1, 1'b1);
`ifdef MEM_TIMEOUT_EN
        run_txn("t5_timeout", 1'b1, 1'b0, 32'h0000_0080, 4'h0, 32'h0, 1000, 0, 1'b0);
        run_txn("t5_after", 1'b1, 1'b0, 32'h0000_1004, 4'h0, 32'h0, 0, 0, 1'b0);
`endif
        for (int i = 0; i < 40; i++) begin
            a = {24'h0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            r = 1'($urandom_range(0, 1));
            wbit = r ? 1'($urandom_range(0, 1)) : 1'b1;
            run_txn("rnd", r, wbit, a, 4'($urandom_range(0, 15)), $urandom,
                    $urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end
        reset_in_wait();
        run_txn("post_rst", 1'b1, 1'b0, 32'h0000_1004, 4'h0, 32'h0, 2, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
